foreground_line_scheduler: RTL and testbench
============================================

# foreground_line_scheduler

Per-scanline object scheduler for the foreground layer. On each line-start strobe it scans all 64 Object Memory entries in priority order (entry 0 first). Up to MAX_SLOTS objects that intersect the requested line are copied, together with their pattern row index, into a slot table. The downstream foreground renderer then evaluates only those slots rather than all 64 objects in parallel. It sits between OBM (read side) and the foreground pixel pipeline.

## Interface
- MAX_SLOTS, 8: slot table depth, i.e. the maximum number of objects rendered per line. Must be ≥1.
- SLOT_IDX_W, $clog2(MAX_SLOTS) (min 1): width of slot index and count.

Ports:
- clk  input  1  pixel clock, 12.5875 MHz
- rst  input  1  asynchronous, active-low reset
- line_start  input  1  one-cycle strobe; begin scan for line yp_next
- yp_next  input  8  target scanline, valid 0–239, sampled when line_start=1
- obm_addr  output  8  OBM byte address {obma[5:0], field[1:0]}
- obm_re  output  1  OBM read enable
- obm_data  input  8  OBM read data, valid the cycle after obm_addr/obm_re
- slot_we  output  1  slot write strobe
- slot_idx  output  SLOT_IDX_W  slot written
- slot_data  output  32  {XP, YP, attr, color}, in OBM byte order
- slot_row  output  3  yp_next − YP, before vflip
- slot_count  output  SLOT_IDX_W+1  slots filled for the current scan
- busy  output  1  scan in progress
- done  output  1  one-cycle pulse at scan completion
- overflow  output  1  more than MAX_SLOTS hits on this line

## Operation
- States:
  - IDLE
  - FETCH_Y: obm_addr={obma,2'd1}, obm_re=1
  - EVAL_Y: compare YP
  - GET_X: issue {obma,2'd2}; capture XP
  - GET_A: issue {obma,2'd3}; capture attr
  - GET_C: capture color; slot_we=1
  - FINISH
- line_start in any state:
  - latch yp_next, set obma=0, clear slot_count and overflow, enter FETCH_Y.
- EVAL_Y hit test is 9-bit and unsigned: {1'b0,YP} ≤ {1'b0,yp_next} < {1'b0,YP}+9'd8. There is no wrap, so YP ≥ 0xF9 never matches rows 0–6.
- Hit, slots not full:
  - EVAL_Y issues {obma,2'd0} and captures YP, then GET_X → GET_A → GET_C.
  - In GET_C: slot_idx=slot_count, slot_count increments, and obma advances.
- Miss: obma advances, then FETCH_Y.
- After obma=63 completes, go to FINISH: done=1 for one cycle, then IDLE.
- Hit while slot_count==MAX_SLOTS: set overflow (see Configuration). No slot write.
- slot_data, slot_row and slot_idx are valid only while slot_we=1.

## Timing
- Reset values: obm_addr=0, obm_re=0, slot_we=0, slot_idx=0, slot_data=0, slot_row=0, slot_count=0, busy=0, done=0, overflow=0. State=IDLE.
- Miss costs 2 cycles; hit costs 5 cycles.
- Worst-case scan: MAX_SLOTS·5 + (64−MAX_SLOTS)·2 + 1 = 153 cycles at default settings. This fits within one 400-cycle line period, so line_start is issued one line ahead.
- busy=1 from the cycle after line_start through the FINISH cycle inclusive.
- First obm_re is asserted the cycle after line_start.
- line_start coinciding with FINISH or GET_C:
  - restart wins; done and slot_we are suppressed that cycle.
  - The slot table contents from the aborted scan are invalid.
- Reset asserted mid-scan returns all outputs to reset values immediately. No slot write completes.
- overflow stays stable from its set cycle until the next line_start or reset.

## Configuration
- FG_OVERFLOW_SCAN_EN defined:
  - After the table fills, scanning continues through obma=63, evaluating YP only (2 cycles/object).
  - overflow is set on the first extra hit.
  - done timing follows the full scan.
- Undefined:
  - The scan terminates into FINISH on the cycle after the MAX_SLOTS-th GET_C.
  - overflow is tied to 0.

## Test plan
- Single object: entry 5 at XP=0x40, YP=100, attr=0x61, color=3; yp_next=103.
  - Required: one slot_we with slot_idx=0, slot_data=0x40646103, slot_row=3.
  - slot_count=1, done pulses.
- Boundaries: YP=100 with yp_next=99, 100, 107, 108 → hit only for 100 and 107. YP=0xFC with yp_next=2 → no hit.
- Priority/overflow: 10 objects (entries 0–9) on line 50, MAX_SLOTS=8.
  - Required: slots hold entries 0–7 in order; slot_count=8.
  - overflow=1 with FG_OVERFLOW_SCAN_EN, 0 without.
  - done latency must equal the computed cycle count.
- Empty line: all YP=0xFF, yp_next=10 → no slot_we, done 129 cycles after line_start, slot_count=0.
- Restart: second line_start issued 20 cycles into a scan.
  - Required: slot_count clears, obm_addr returns to 0x01, and exactly one done is produced.
- Reset: assert rst low during GET_A → all outputs at reset values the same cycle. After release, IDLE until line_start.

Source files
------------

// File: rtl/foreground_line_scheduler.sv
// Per-scanline foreground object scheduler: scans 64 OBM entries in priority order and fills a slot table.
// Optional build macro FG_OVERFLOW_SCAN_EN keeps scanning after the table fills so overflow can be flagged.
module foreground_line_scheduler #(
    parameter int MAX_SLOTS  = 8,
    parameter int SLOT_IDX_W = (MAX_SLOTS > 1) ? $clog2(MAX_SLOTS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  line_start,
    input  logic [7:0]            yp_next,
    output logic [7:0]            obm_addr,
    output logic                  obm_re,
    input  logic [7:0]            obm_data,
    output logic                  slot_we,
    output logic [SLOT_IDX_W-1:0] slot_idx,
    output logic [31:0]           slot_data,
    output logic [2:0]            slot_row,
    output logic [SLOT_IDX_W:0]   slot_count,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH_Y,
        EVAL_Y,
        GET_X,
        GET_A,
        GET_C,
        FINISH
    } state_t;

    localparam logic [SLOT_IDX_W:0] CNT_MAX = (SLOT_IDX_W+1)'(MAX_SLOTS);
    localparam logic [SLOT_IDX_W:0] CNT_ONE = (SLOT_IDX_W+1)'(1);

    state_t              state, state_nxt;
    logic [5:0]          obma, obma_nxt;
    logic [SLOT_IDX_W:0] count_nxt;
    logic [7:0]          yp_line, yp_obj, xp_obj, attr_obj;
    logic                hit, full, last;

    // Unsigned 9-bit window test; no wrap, so objects near the bottom never reach row 0.
    function automatic logic line_hit(input logic [7:0] yp, input logic [7:0] line);
        logic [8:0] lo;
        logic [8:0] ln;
        lo = {1'b0, yp};
        ln = {1'b0, line};
        return (lo <= ln) && (ln < lo + 9'd8);
    endfunction

    assign hit  = line_hit(obm_data, yp_line);
    assign full = (slot_count == CNT_MAX);
    assign last = (obma == 6'd63);

`ifdef FG_OVERFLOW_SCAN_EN
    logic ovf_q, ovf_nxt;
    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            obma       <= '0;
            slot_count <= '0;
`ifdef FG_OVERFLOW_SCAN_EN
            ovf_q      <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            obma       <= obma_nxt;
            slot_count <= count_nxt;
`ifdef FG_OVERFLOW_SCAN_EN
            ovf_q      <= ovf_nxt;
`endif
        end
    end

    // Object byte capture: data registers carry no reset, outputs are gated by slot_we instead.
    always_ff @(posedge clk) begin
        if (line_start) begin
            yp_line <= yp_next;
        end
        case (state)
            EVAL_Y:  yp_obj   <= obm_data;
            GET_X:   xp_obj   <= obm_data;
            GET_A:   attr_obj <= obm_data;
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        obma_nxt  = obma;
        count_nxt = slot_count;
`ifdef FG_OVERFLOW_SCAN_EN
        ovf_nxt   = ovf_q;
`endif
        obm_addr  = 8'd0;
        obm_re    = 1'b0;
        slot_we   = 1'b0;
        done      = 1'b0;

        case (state)
            FETCH_Y: begin
                obm_addr  = {obma, 2'd1};
                obm_re    = 1'b1;
                state_nxt = EVAL_Y;
            end
            EVAL_Y: begin
                if (hit && !full) begin
                    obm_addr  = {obma, 2'd0};
                    obm_re    = 1'b1;
                    state_nxt = GET_X;
                end else begin
`ifdef FG_OVERFLOW_SCAN_EN
                    if (hit) begin
                        ovf_nxt = 1'b1;
                    end
`endif
                    obma_nxt  = obma + 6'd1;
                    state_nxt = last ? FINISH : FETCH_Y;
                end
            end
            GET_X: begin
                obm_addr  = {obma, 2'd2};
                obm_re    = 1'b1;
                state_nxt = GET_A;
            end
            GET_A: begin
                obm_addr  = {obma, 2'd3};
                obm_re    = 1'b1;
                state_nxt = GET_C;
            end
            GET_C: begin
                slot_we   = 1'b1;
                count_nxt = slot_count + CNT_ONE;
                obma_nxt  = obma + 6'd1;
`ifdef FG_OVERFLOW_SCAN_EN
                state_nxt = last ? FINISH : FETCH_Y;
`else
                state_nxt = (last || count_nxt == CNT_MAX) ? FINISH : FETCH_Y;
`endif
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: ;
        endcase

        // A new line request aborts whatever is in flight.
        if (line_start) begin
            state_nxt = FETCH_Y;
            obma_nxt  = '0;
            count_nxt = '0;
`ifdef FG_OVERFLOW_SCAN_EN
            ovf_nxt   = 1'b0;
`endif
            slot_we   = 1'b0;
            done      = 1'b0;
        end
    end

    assign busy      = (state != IDLE);
    assign slot_idx  = slot_we ? slot_count[SLOT_IDX_W-1:0] : '0;
    assign slot_data = slot_we ? {xp_obj, yp_obj, attr_obj, obm_data} : 32'd0;
    assign slot_row  = slot_we ? (yp_line[2:0] - yp_obj[2:0]) : 3'd0;

endmodule

// File: tb/tb_foreground_line_scheduler.sv
// Self-checking bench for foreground_line_scheduler against a behavioural per-line object model.
`timescale 1ns/1ps
module tb_foreground_line_scheduler;
    localparam int MAX_SLOTS = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          line_start = 1'b0;
    logic [7:0]    yp_next = 8'd0;
    logic [7:0]    obm_addr;
    logic          obm_re;
    logic [7:0]    obm_data;
    logic          slot_we;
    logic [IW-1:0] slot_idx;
    logic [31:0]   slot_data;
    logic [2:0]    slot_row;
    logic [IW:0]   slot_count;
    logic          busy, done, overflow;

    logic [7:0] mem [256];
    logic [7:0] rd_q = 8'h00;

    int checks = 0;
    int failures = 0;

    logic [31:0] got_data[$];
    logic [2:0]  got_row[$];
    int          got_idx[$];
    int          done_cnt, done_cyc, busy_err, cyc;

    logic [31:0] exp_data [MAX_SLOTS];
    logic [2:0]  exp_row [MAX_SLOTS];
    int          exp_n, exp_cyc;
    logic        exp_ovf;

    always #40 clk = ~clk;

    always @(posedge clk) begin
        if (obm_re) rd_q <= mem[obm_addr];
    end
    assign obm_data = rd_q;

    foreground_line_scheduler #(.MAX_SLOTS(MAX_SLOTS)) dut (
        .clk(clk), .rst(rst), .line_start(line_start), .yp_next(yp_next),
        .obm_addr(obm_addr), .obm_re(obm_re), .obm_data(obm_data),
        .slot_we(slot_we), .slot_idx(slot_idx), .slot_data(slot_data), .slot_row(slot_row),
        .slot_count(slot_count), .busy(busy), .done(done), .overflow(overflow)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_obm_addr"}, obm_addr, 0);
        chk({tag, "_obm_re"}, obm_re, 0);
        chk({tag, "_slot_we"}, slot_we, 0);
        chk({tag, "_slot_idx"}, slot_idx, 0);
        chk({tag, "_slot_data"}, slot_data, 0);
        chk({tag, "_slot_row"}, slot_row, 0);
        chk({tag, "_slot_count"}, slot_count, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_overflow"}, overflow, 0);
    endtask

    // Reference: walk entries in priority order, first MAX_SLOTS hits fill slots.
    // Each copied hit costs 5 cycles, anything else 2, plus one finishing cycle.
    task automatic model(input logic [7:0] y);
        int yp;
        bit h;
        bit stop;
        exp_n = 0;
        exp_ovf = 1'b0;
        exp_cyc = 1;
        stop = 1'b0;
        for (int e = 0; e < 64 && !stop; e++) begin
            yp = int'(mem[4*e+1]);
            h = (yp <= int'(y)) && (int'(y) < yp + 8);
            if (h && exp_n < MAX_SLOTS) begin
                exp_data[exp_n] = {mem[4*e], mem[4*e+1], mem[4*e+2], mem[4*e+3]};
                exp_row[exp_n] = 3'(int'(y) - yp);
                exp_n++;
                exp_cyc += 5;
`ifndef FG_OVERFLOW_SCAN_EN
                if (exp_n == MAX_SLOTS) stop = 1'b1;
`endif
            end else begin
                if (h) exp_ovf = 1'b1;
                exp_cyc += 2;
            end
        end
    endtask

    task automatic fill_empty();
        for (int e = 0; e < 64; e++) begin
            mem[4*e]   = 8'($urandom);
            mem[4*e+1] = 8'hFF;
            mem[4*e+2] = 8'($urandom);
            mem[4*e+3] = 8'($urandom);
        end
    endtask

    task automatic set_obj(input int e, input logic [7:0] xp, input logic [7:0] yp,
                           input logic [7:0] at, input logic [7:0] col);
        mem[4*e]   = xp;
        mem[4*e+1] = yp;
        mem[4*e+2] = at;
        mem[4*e+3] = col;
    endtask

    task automatic clear_obs();
        got_data.delete();
        got_row.delete();
        got_idx.delete();
        done_cnt = 0;
        done_cyc = -1;
        busy_err = 0;
    endtask

    task automatic start_line(input logic [7:0] y);
        @(negedge clk);
        line_start = 1'b1;
        yp_next = y;
        @(negedge clk);
        line_start = 1'b0;
        cyc = 1;
    endtask

    task automatic collect(input int n);
        for (int i = 0; i < n; i++) begin
            if (busy !== (done_cnt == 0)) busy_err++;
            if (slot_we === 1'b1) begin
                got_data.push_back(slot_data);
                got_row.push_back(slot_row);
                got_idx.push_back(int'(slot_idx));
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check_scan(input string tag, input logic [7:0] y);
        model(y);
        chk({tag, "_nslots"}, got_data.size(), exp_n);
        for (int i = 0; i < exp_n && i < got_data.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
            chk($sformatf("%s_row%0d", tag, i), got_row[i], exp_row[i]);
            chk($sformatf("%s_idx%0d", tag, i), got_idx[i], i);
        end
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_done_cyc"}, done_cyc, exp_cyc);
        chk({tag, "_slot_count"}, slot_count, exp_n);
        chk({tag, "_overflow"}, overflow, exp_ovf);
        chk({tag, "_busy"}, busy_err, 0);
    endtask

    task automatic full_scan(input string tag, input logic [7:0] y);
        clear_obs();
        start_line(y);
        chk({tag, "_first_re"}, obm_re, 1);
        chk({tag, "_first_addr"}, obm_addr, 8'h01);
        collect(170);
        check_scan(tag, y);
    endtask

    initial begin
        int by [4];
        int bn [4];
        int ry;
        int err;
        bit found;
        by = '{99, 100, 107, 108};
        bn = '{0, 1, 1, 0};

        fill_empty();
        repeat (2) @(negedge clk);
        chk_reset_outputs("por");
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_re", obm_re, 0);

        // single object
        set_obj(5, 8'h40, 8'd100, 8'h61, 8'h03);
        full_scan("single", 8'd103);
        chk("single_n_const", got_data.size(), 1);
        if (got_data.size() != 0) begin
            chk("single_data_const", got_data[0], 32'h40646103);
            chk("single_row_const", got_row[0], 3);
            chk("single_idx_const", got_idx[0], 0);
        end
        chk("single_count_const", slot_count, 1);
        chk("single_done_const", done_cyc, 132);

        // window boundaries
        fill_empty();
        set_obj(0, 8'h11, 8'd100, 8'h22, 8'h33);
        for (int k = 0; k < 4; k++) begin
            full_scan($sformatf("bound%0d", by[k]), 8'(by[k]));
            chk($sformatf("bound%0d_const", by[k]), slot_count, bn[k]);
        end
        set_obj(0, 8'h11, 8'hFC, 8'h22, 8'h33);
        full_scan("nowrap", 8'd2);
        chk("nowrap_const", slot_count, 0);

        // priority and overflow
        fill_empty();
        for (int e = 0; e < 10; e++) set_obj(e, 8'($urandom), 8'd50, 8'($urandom), 8'($urandom));
        full_scan("ovf", 8'd50);
        chk("ovf_count_const", slot_count, 8);
        if (got_data.size() == 8) chk("ovf_last_xp", got_data[7][31:24], mem[28]);
`ifdef FG_OVERFLOW_SCAN_EN
        chk("ovf_flag_const", overflow, 1);
        chk("ovf_done_const", done_cyc, 153);
`else
        chk("ovf_flag_const", overflow, 0);
        chk("ovf_done_const", done_cyc, 41);
`endif

        // empty line
        fill_empty();
        full_scan("empty", 8'd10);
        chk("empty_done_const", done_cyc, 129);
        chk("empty_count_const", slot_count, 0);

        // randomized lines
        for (int r = 0; r < 8; r++) begin
            ry = (r == 0) ? 3 : int'($urandom_range(0, 239));
            for (int e = 0; e < 64; e++) begin
                if ($urandom_range(0, r % 4 + 1) == 0)
                    set_obj(e, 8'($urandom), 8'(ry - int'($urandom_range(0, 9))), 8'($urandom), 8'($urandom));
                else
                    set_obj(e, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            end
            full_scan($sformatf("rand%0d", r), 8'(ry));
        end

        // restart 20 cycles into a scan (cycle 20 is the fourth slot write)
        fill_empty();
        for (int e = 0; e < 10; e++) set_obj(e, 8'($urandom), 8'd50, 8'($urandom), 8'($urandom));
        clear_obs();
        start_line(8'd50);
        collect(19);
        line_start = 1'b1;
        yp_next = 8'd50;
        #1;
        chk("restart_we_suppressed", slot_we, 0);
        chk("restart_pre_writes", got_data.size(), 3);
        chk("restart_pre_done", done_cnt, 0);
        @(negedge clk);
        line_start = 1'b0;
        cyc = 1;
        chk("restart_count_clear", slot_count, 0);
        chk("restart_addr", obm_addr, 8'h01);
        clear_obs();
        collect(170);
        check_scan("restart", 8'd50);

        // asynchronous reset during GET_A
        fill_empty();
        set_obj(5, 8'h40, 8'd100, 8'h61, 8'h03);
        clear_obs();
        start_line(8'd103);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (obm_re === 1'b1 && obm_addr === 8'h17) found = 1'b1;
            else @(negedge clk);
        end
        chk("rst_reach_get_a", found, 1);
        rst = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b1;
        err = 0;
        for (int i = 0; i < 6; i++) begin
            if (slot_we !== 1'b0 || busy !== 1'b0 || obm_re !== 1'b0 || done !== 1'b0) err++;
            @(negedge clk);
        end
        chk("postrst_idle", err, 0);
        full_scan("postrst", 8'd103);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
